// File: rtl/reg_file_sb.sv
// General-purpose register file with two combinational read ports, one write port,
// and a per-register busy scoreboard used by decode to reserve destination registers.
module reg_file_sb #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          read_index1,
  input  logic [ADDR_W-1:0]          read_index2,
  output logic [DATA_W-1:0]          read_data1,
  output logic [DATA_W-1:0]          read_data2,
  output logic                       read_ready1,
  output logic                       read_ready2,
  input  logic                       write_enable,
  input  logic [ADDR_W-1:0]          write_index,
  input  logic [DATA_W-1:0]          write_data,
  input  logic                       rsv_enable,
  input  logic [ADDR_W-1:0]          rsv_index,
  output logic                       rsv_grant,
  output logic [(1 << ADDR_W)-1:0]   busy_vec
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy_next;
  logic              wr_hit1;
  logic              wr_hit2;
  logic              rsv_wr_hit;

  // Read ports: stored value, optionally overridden by same-cycle writeback
  always_comb begin
    wr_hit1     = BYPASS && write_enable && (write_index == read_index1);
    wr_hit2     = BYPASS && write_enable && (write_index == read_index2);
    read_data1  = wr_hit1 ? write_data : regs[read_index1];
    read_data2  = wr_hit2 ? write_data : regs[read_index2];
    read_ready1 = wr_hit1 | ~busy_vec[read_index1];
    read_ready2 = wr_hit2 | ~busy_vec[read_index2];
  end

  // A busy register may be re-reserved only when it is being written back this cycle
  always_comb begin
    rsv_wr_hit = write_enable && (write_index == rsv_index);
    rsv_grant  = rsv_enable & ~reset & (~busy_vec[rsv_index] | rsv_wr_hit);
    busy_next  = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      busy_next[i] = (rsv_grant && (rsv_index == ADDR_W'(i))) |
                     (busy_vec[i] & ~(write_enable && (write_index == ADDR_W'(i))));
    end
  end

  // Register storage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable) begin
      regs[write_index] <= write_data;
    end
  end

  // Scoreboard
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: bypass, no-bypass and wide instances compared
// every cycle against an array-based model of the register file and scoreboard.
module tb_reg_file_sb;

  logic clk;
  logic reset;

  // Narrow stimulus shared by the bypass and no-bypass instances
  logic [2:0]  n_ri1, n_ri2, n_wi, n_rsi;
  logic        n_we, n_re;
  logic [15:0] n_wd;
  logic [15:0] b_rd1, b_rd2, x_rd1, x_rd2;
  logic        b_rdy1, b_rdy2, x_rdy1, x_rdy2, b_gnt, x_gnt;
  logic [7:0]  b_busy, x_busy;

  // Wide instance
  logic [3:0]  w_ri1, w_ri2, w_wi, w_rsi;
  logic        w_we, w_re;
  logic [31:0] w_wd;
  logic [31:0] w_rd1, w_rd2;
  logic        w_rdy1, w_rdy2, w_gnt;
  logic [15:0] w_busy;

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset),
    .read_index1(n_ri1), .read_index2(n_ri2),
    .read_data1(b_rd1), .read_data2(b_rd2),
    .read_ready1(b_rdy1), .read_ready2(b_rdy2),
    .write_enable(n_we), .write_index(n_wi), .write_data(n_wd),
    .rsv_enable(n_re), .rsv_index(n_rsi), .rsv_grant(b_gnt),
    .busy_vec(b_busy)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b0)) u_nobyp (
    .clk(clk), .reset(reset),
    .read_index1(n_ri1), .read_index2(n_ri2),
    .read_data1(x_rd1), .read_data2(x_rd2),
    .read_ready1(x_rdy1), .read_ready2(x_rdy2),
    .write_enable(n_we), .write_index(n_wi), .write_data(n_wd),
    .rsv_enable(n_re), .rsv_index(n_rsi), .rsv_grant(x_gnt),
    .busy_vec(x_busy)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(4), .BYPASS(1'b1)) u_wide (
    .clk(clk), .reset(reset),
    .read_index1(w_ri1), .read_index2(w_ri2),
    .read_data1(w_rd1), .read_data2(w_rd2),
    .read_ready1(w_rdy1), .read_ready2(w_rdy2),
    .write_enable(w_we), .write_index(w_wi), .write_data(w_wd),
    .rsv_enable(w_re), .rsv_index(w_rsi), .rsv_grant(w_gnt),
    .busy_vec(w_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: index 0 = narrow file (shared by both narrow DUTs), 1 = wide file
  logic [31:0] m_mem  [2][16];
  bit          m_busy [2][16];
  bit          model_valid;
  int          checks;
  int          failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(int k, bit byp, int ri, bit we, int wi, logic [31:0] wd);
    if (byp && we && wi == ri) return wd;
    return m_mem[k][ri];
  endfunction

  function automatic logic exp_ready(int k, bit byp, int ri, bit we, int wi);
    if (byp && we && wi == ri) return 1'b1;
    return !m_busy[k][ri];
  endfunction

  function automatic logic exp_grant(int k, bit re, int rsi, bit we, int wi);
    return re && !reset && (!m_busy[k][rsi] || (we && wi == rsi));
  endfunction

  function automatic logic [15:0] exp_busy(int k, int nreg);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < nreg; i++) v[i] = m_busy[k][i];
    return v;
  endfunction

  task automatic check_inst(input int k, input bit byp, input string tag, input int nreg,
                            input int ri1, input int ri2, input bit we, input int wi,
                            input logic [31:0] wd, input bit re, input int rsi,
                            input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic rdy1, input logic rdy2, input logic gnt,
                            input logic [15:0] busyv);
    chk({tag, ".rd1"},  rd1, exp_data(k, byp, ri1, we, wi, wd));
    chk({tag, ".rd2"},  rd2, exp_data(k, byp, ri2, we, wi, wd));
    chk({tag, ".rdy1"}, 32'(rdy1), 32'(exp_ready(k, byp, ri1, we, wi)));
    chk({tag, ".rdy2"}, 32'(rdy2), 32'(exp_ready(k, byp, ri2, we, wi)));
    chk({tag, ".gnt"},  32'(gnt), 32'(exp_grant(k, re, rsi, we, wi)));
    chk({tag, ".busy"}, 32'(busyv), 32'(exp_busy(k, nreg)));
  endtask

  // Apply the posedge the current inputs will see
  task automatic model_update(input int k, input bit we, input int wi, input logic [31:0] wd,
                              input bit re, input int rsi);
    bit g;
    g = exp_grant(k, re, rsi, we, wi);
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_mem[k][i]  = '0;
        m_busy[k][i] = 1'b0;
      end
    end else begin
      if (we) begin
        m_mem[k][wi]  = wd;
        m_busy[k][wi] = 1'b0;
      end
      if (g) m_busy[k][rsi] = 1'b1;
    end
  endtask

  // One clock: compare all outputs mid-cycle, advance the model, then step past the edge
  task automatic cycle();
    @(negedge clk);
    if (model_valid) begin
      check_inst(0, 1'b1, "byp", 8, int'(n_ri1), int'(n_ri2), n_we, int'(n_wi), 32'(n_wd),
                 n_re, int'(n_rsi), 32'(b_rd1), 32'(b_rd2), b_rdy1, b_rdy2, b_gnt, 16'(b_busy));
      check_inst(0, 1'b0, "nob", 8, int'(n_ri1), int'(n_ri2), n_we, int'(n_wi), 32'(n_wd),
                 n_re, int'(n_rsi), 32'(x_rd1), 32'(x_rd2), x_rdy1, x_rdy2, x_gnt, 16'(x_busy));
      check_inst(1, 1'b1, "wide", 16, int'(w_ri1), int'(w_ri2), w_we, int'(w_wi), w_wd,
                 w_re, int'(w_rsi), w_rd1, w_rd2, w_rdy1, w_rdy2, w_gnt, w_busy);
    end
    model_update(0, n_we, int'(n_wi), 32'(n_wd), n_re, int'(n_rsi));
    model_update(1, w_we, int'(w_wi), w_wd, w_re, int'(w_rsi));
    if (reset) model_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0;
    n_we = 1'b0; n_re = 1'b0; n_wi = '0; n_wd = '0; n_rsi = '0;
    w_we = 1'b0; w_re = 1'b0; w_wi = '0; w_wd = '0; w_rsi = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_valid = 1'b0;
    idle();
    n_ri1 = '0; n_ri2 = '0; w_ri1 = '0; w_ri2 = '0;

    // Reset then read
    reset = 1'b1;
    cycle();
    idle();
    n_ri1 = 3'd3; n_ri2 = 3'd7;
    #1;
    chk("rst.rd1", 32'(b_rd1), 32'h0);
    chk("rst.rd2", 32'(b_rd2), 32'h0);
    chk("rst.rdy", 32'({b_rdy1, b_rdy2}), 32'h3);
    chk("rst.busy", 32'(b_busy), 32'h0);
    cycle();

    // Write with same-cycle read
    n_we = 1'b1; n_wi = 3'd5; n_wd = 16'hBEEF; n_ri1 = 3'd5;
    #1;
    chk("byp.same", 32'(b_rd1), 32'hBEEF);
    chk("byp.rdy", 32'(b_rdy1), 32'h1);
    chk("nob.same", 32'(x_rd1), 32'h0);
    cycle();
    n_we = 1'b0;
    #1;
    chk("byp.next", 32'(b_rd1), 32'hBEEF);
    chk("nob.next", 32'(x_rd1), 32'hBEEF);
    cycle();

    // Reserve, failed re-reserve, writeback clears
    n_re = 1'b1; n_rsi = 3'd2;
    #1;
    chk("rsv.gnt", 32'(b_gnt), 32'h1);
    cycle();
    n_re = 1'b0; n_ri1 = 3'd2;
    #1;
    chk("rsv.busy", 32'(b_busy), 32'h04);
    chk("rsv.rdy", 32'(b_rdy1), 32'h0);
    n_re = 1'b1;
    #1;
    chk("rsv.again", 32'(b_gnt), 32'h0);
    cycle();
    n_re = 1'b0;
    #1;
    chk("rsv.hold", 32'(b_busy), 32'h04);
    n_we = 1'b1; n_wi = 3'd2; n_wd = 16'h1234;
    cycle();
    n_we = 1'b0;
    #1;
    chk("wb.busy", 32'(b_busy), 32'h0);
    chk("wb.rd", 32'(x_rd1), 32'h1234);
    cycle();

    // Write and reserve the same busy register
    n_re = 1'b1; n_rsi = 3'd4;
    cycle();
    n_we = 1'b1; n_wi = 3'd4; n_wd = 16'h00FF;
    #1;
    chk("col.gnt", 32'(b_gnt), 32'h1);
    cycle();
    idle();
    n_ri1 = 3'd4;
    #1;
    chk("col.rd", 32'(b_rd1), 32'h00FF);
    chk("col.busy", 32'(b_busy), 32'h10);
    chk("col.rdy", 32'(b_rdy1), 32'h0);
    cycle();

    // Reset in the middle of pending reservations
    n_we = 1'b1; n_wi = 3'd1; n_wd = 16'hAAAA; cycle();
    n_wi = 3'd6; cycle();
    idle(); n_re = 1'b1; n_rsi = 3'd1; cycle();
    n_rsi = 3'd6; cycle();
    reset = 1'b1; n_re = 1'b1; n_rsi = 3'd3; n_we = 1'b1; n_wi = 3'd1; n_wd = 16'h5555;
    #1;
    chk("mrst.gnt", 32'(b_gnt), 32'h0);
    cycle();
    idle();
    n_ri1 = 3'd1; n_ri2 = 3'd6;
    #1;
    chk("mrst.rd1", 32'(b_rd1), 32'h0);
    chk("mrst.rd2", 32'(b_rd2), 32'h0);
    chk("mrst.busy", 32'(b_busy), 32'h0);
    cycle();

    // Wide instance: top register
    w_we = 1'b1; w_wi = 4'd15; w_wd = 32'hDEADBEEF; cycle();
    w_we = 1'b0; w_re = 1'b1; w_rsi = 4'd15; cycle();
    w_re = 1'b0; w_ri1 = 4'd15; w_ri2 = 4'd15;
    #1;
    chk("wide.rd1", w_rd1, 32'hDEADBEEF);
    chk("wide.rd2", w_rd2, 32'hDEADBEEF);
    chk("wide.rdy", 32'({w_rdy1, w_rdy2}), 32'h0);
    chk("wide.busy", 32'(w_busy), 32'h8000);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      n_ri1 = 3'($urandom); n_ri2 = 3'($urandom);
      n_we  = 1'($urandom); n_wi = 3'($urandom); n_wd = 16'($urandom);
      n_re  = 1'($urandom); n_rsi = 3'($urandom);
      w_ri1 = 4'($urandom); w_ri2 = 4'($urandom);
      w_we  = 1'($urandom); w_wi = 4'($urandom); w_wd = $urandom;
      w_re  = 1'($urandom); w_rsi = 4'($urandom);
      if ($urandom_range(0, 3) == 0) n_rsi = n_wi;
      if ($urandom_range(0, 3) == 0) n_ri1 = n_wi;
      if ($urandom_range(0, 3) == 0) w_rsi = w_wi;
      if ($urandom_range(0, 3) == 0) w_ri2 = w_wi;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised general-purpose register file for the CORE datapath: 2 asynchronous read ports, 1 synchronous write port, and a per-register busy scoreboard.
- The decode stage reserves a destination register. Readers see a ready flag per port. Writeback clears the reservation.
- An optional write-to-read bypass forwards same-cycle writeback data.
- Sits between decode/issue and the ALU and writeback stages.

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, index width; depth NREG = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port; 0 = read returns stored value

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- read_index1  in  ADDR_W  read port 1 register index
- read_index2  in  ADDR_W  read port 2 register index
- read_data1  out  DATA_W  port 1 data (combinational)
- read_data2  out  DATA_W  port 2 data (combinational)
- read_ready1  out  1  port 1 register not pending (combinational)
- read_ready2  out  1  port 2 register not pending (combinational)
- write_enable  in  1  writeback strobe
- write_index  in  ADDR_W  writeback register index
- write_data  in  DATA_W  writeback data
- rsv_enable  in  1  reservation request
- rsv_index  in  ADDR_W  register to reserve
- rsv_grant  out  1  reservation accepted this cycle (combinational)
- busy_vec  out  NREG  registered busy bit per register, bit i = register i

Behaviour:
- Reset: synchronous, active-high; clk and reset fixed as named in Ports.
  - When reset=1 at a posedge, all NREG registers become 0 and busy_vec becomes 0.
  - Reset overrides any write or reservation in the same cycle.
  - rsv_grant is forced to 0 while reset=1.
  - With reset asserted mid-operation, every pending reservation is dropped; no writeback is required afterwards.
- Read, each port independent:
  - read_data = reg[index], read_ready = ~busy[index], zero cycles of latency.
  - BYPASS=1 and write_enable=1 and write_index==read_index: read_data = write_data, read_ready = 1.
  - BYPASS=0: read returns the old stored value and ready reflects the current busy bit. The new value is visible from the next cycle.
  - Both ports may address the same register; each gets identical results.
- Write: when write_enable=1, reg[write_index] <= write_data at the posedge.
  - Busy bit of write_index is cleared unless it is re-reserved in the same cycle (see below).
  - Writing a non-busy register is legal: data is updated and busy stays 0.
- Reservation:
  - rsv_grant = rsv_enable & ~reset & (~busy[rsv_index] | (write_enable & write_index==rsv_index)).
  - On grant, busy[rsv_index] <= 1 at the posedge.
  - Request to an already-busy register with no matching write: rsv_grant=0, no state change. The requester retries; the block has no queueing.
  - Simultaneous write and reserve, same index: data is written, busy ends at 1, grant=1. The new reservation wins.
  - Simultaneous write and reserve, different indices: both take effect independently.
- Per-register next-state busy function:
  - busy_next[i] = reset ? 0 : (grant & rsv_index==i) | (busy[i] & ~(write_enable & write_index==i)).
- No special-purpose registers: index 0 is an ordinary storage register.
- Widths are exact. write_data is stored unmodified; no sign extension or truncation.

Test Plan:
- Reset then reads: assert reset 1 cycle; read_index1=3, read_index2=7 -> read_data1=read_data2=0x0000, both ready=1, busy_vec=0.
- Write/read, BYPASS=1: write 0xBEEF to reg 5 with read_index1=5 in the same cycle -> read_data1=0xBEEF, ready1=1. Next cycle with write_enable=0 -> still 0xBEEF. Repeat with BYPASS=0 -> same-cycle read returns 0x0000, next cycle 0xBEEF.
- Reserve/clear: reserve reg 2 -> rsv_grant=1, next cycle busy_vec[2]=1 and read_ready on index 2 =0. Re-reserve reg 2 -> rsv_grant=0, busy unchanged. Write 0x1234 to reg 2 -> busy_vec[2]=0 next cycle, read returns 0x1234.
- Collision: reg 4 busy; same cycle write_enable to reg 4 with 0x00FF and rsv_enable to reg 4 -> rsv_grant=1, reg4=0x00FF, busy_vec[4]=1 after the edge.
- Reset mid-operation: regs 1 and 6 reserved and holding 0xAAAA; assert reset together with write_enable(reg 1, 0x5555) and rsv_enable(reg 3) -> rsv_grant=0, all regs 0, busy_vec=0 after the edge.
- Parametric: ADDR_W=4, DATA_W=32 -> write 0xDEADBEEF to reg 15, reserve reg 15, read on both ports -> data 0xDEADBEEF, both ready=0, busy_vec=16'h8000.
